// File: rtl/rom4_mult_lut.sv
// 4x4-bit unsigned multiplier as a 256-entry constant product table.
// dout is the same-cycle table read; dout_q is a registered copy with one clock of latency.
module rom4_mult_lut #(
   parameter int unsigned WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [2*WIDTH-1:0] addr,
   output logic [2*WIDTH-1:0] dout,
   output logic [2*WIDTH-1:0] dout_q
);

   // Row a holds a*b for b = 0..15; the address is {a, b}.
   localparam logic [7:0] ProdRom [256] = '{
      8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
      8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
      8'd0,   8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   8'd7,
      8'd8,   8'd9,   8'd10,  8'd11,  8'd12,  8'd13,  8'd14,  8'd15,
      8'd0,   8'd2,   8'd4,   8'd6,   8'd8,   8'd10,  8'd12,  8'd14,
      8'd16,  8'd18,  8'd20,  8'd22,  8'd24,  8'd26,  8'd28,  8'd30,
      8'd0,   8'd3,   8'd6,   8'd9,   8'd12,  8'd15,  8'd18,  8'd21,
      8'd24,  8'd27,  8'd30,  8'd33,  8'd36,  8'd39,  8'd42,  8'd45,
      8'd0,   8'd4,   8'd8,   8'd12,  8'd16,  8'd20,  8'd24,  8'd28,
      8'd32,  8'd36,  8'd40,  8'd44,  8'd48,  8'd52,  8'd56,  8'd60,
      8'd0,   8'd5,   8'd10,  8'd15,  8'd20,  8'd25,  8'd30,  8'd35,
      8'd40,  8'd45,  8'd50,  8'd55,  8'd60,  8'd65,  8'd70,  8'd75,
      8'd0,   8'd6,   8'd12,  8'd18,  8'd24,  8'd30,  8'd36,  8'd42,
      8'd48,  8'd54,  8'd60,  8'd66,  8'd72,  8'd78,  8'd84,  8'd90,
      8'd0,   8'd7,   8'd14,  8'd21,  8'd28,  8'd35,  8'd42,  8'd49,
      8'd56,  8'd63,  8'd70,  8'd77,  8'd84,  8'd91,  8'd98,  8'd105,
      8'd0,   8'd8,   8'd16,  8'd24,  8'd32,  8'd40,  8'd48,  8'd56,
      8'd64,  8'd72,  8'd80,  8'd88,  8'd96,  8'd104, 8'd112, 8'd120,
      8'd0,   8'd9,   8'd18,  8'd27,  8'd36,  8'd45,  8'd54,  8'd63,
      8'd72,  8'd81,  8'd90,  8'd99,  8'd108, 8'd117, 8'd126, 8'd135,
      8'd0,   8'd10,  8'd20,  8'd30,  8'd40,  8'd50,  8'd60,  8'd70,
      8'd80,  8'd90,  8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150,
      8'd0,   8'd11,  8'd22,  8'd33,  8'd44,  8'd55,  8'd66,  8'd77,
      8'd88,  8'd99,  8'd110, 8'd121, 8'd132, 8'd143, 8'd154, 8'd165,
      8'd0,   8'd12,  8'd24,  8'd36,  8'd48,  8'd60,  8'd72,  8'd84,
      8'd96,  8'd108, 8'd120, 8'd132, 8'd144, 8'd156, 8'd168, 8'd180,
      8'd0,   8'd13,  8'd26,  8'd39,  8'd52,  8'd65,  8'd78,  8'd91,
      8'd104, 8'd117, 8'd130, 8'd143, 8'd156, 8'd169, 8'd182, 8'd195,
      8'd0,   8'd14,  8'd28,  8'd42,  8'd56,  8'd70,  8'd84,  8'd98,
      8'd112, 8'd126, 8'd140, 8'd154, 8'd168, 8'd182, 8'd196, 8'd210,
      8'd0,   8'd15,  8'd30,  8'd45,  8'd60,  8'd75,  8'd90,  8'd105,
      8'd120, 8'd135, 8'd150, 8'd165, 8'd180, 8'd195, 8'd210, 8'd225
   };

   assign dout = ProdRom[addr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout;
      end
   end

endmodule

// File: tb/tb_rom4_mult_lut.sv
// Self-checking bench for rom4_mult_lut: directed corners, latency, async reset,
// exhaustive sweep and random addresses against an arithmetic reference.
module tb_rom4_mult_lut;

   logic       clk;
   logic       rst_n;
   logic [7:0] addr;
   logic [7:0] dout;
   logic [7:0] dout_q;

   int n_cmp = 0;
   int n_err = 0;

   rom4_mult_lut #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .addr   (addr),
      .dout   (dout),
      .dout_q (dout_q)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   function automatic int ref_prod(input int a);
      return (a / 16) * (a % 16);
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input int exp);
      n_cmp++;
      assert (obs === 8'(exp))
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, check dout combinationally, then dout_q after the rising edge.
   task automatic step(input int a, input string tag);
      @(negedge clk);
      addr = 8'(a);
      #1 check({tag, "_dout"}, dout, ref_prod(a));
      @(posedge clk);
      #1 check({tag, "_dout_q"}, dout_q, ref_prod(a));
   endtask

   initial begin
      int prev;
      int v;
      int corners [5] = '{8'h00, 8'hFF, 8'hF1, 8'h1F, 8'h0F};
      int typical [3] = '{8'h37, 8'hA5, 8'h88};

      // Reset with addr=FF: dout_q clears without a clock, dout keeps the product.
      rst_n = 1'b1;
      addr  = 8'hFF;
      #2 rst_n = 1'b0;
      #1 check("rst_dout_q", dout_q, 0);
      check("rst_dout", dout, 225);
      @(posedge clk);
      #1 check("rst_hold_dout_q", dout_q, 0);
      check("rst_hold_dout", dout, 225);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (corners[i]) step(corners[i], "corner");
      foreach (typical[i]) step(typical[i], "typical");

      // Back-to-back latency.
      @(negedge clk);
      addr = 8'h23;
      @(posedge clk);
      #1 check("lat_first", dout_q, 6);
      @(negedge clk);
      addr = 8'h45;
      @(posedge clk);
      #1 check("lat_second", dout_q, 20);

      // Reset pulse between edges while a product is held.
      step(8'h99, "pre_rst");
      #1 rst_n = 1'b0;
      #1 check("mid_rst_dout_q", dout_q, 0);
      check("mid_rst_dout", dout, 81);
      #10 rst_n = 1'b1;
      #1 check("post_rel_dout_q", dout_q, 0);
      @(posedge clk);
      #1 check("post_rst_dout_q", dout_q, 81);

      // Exhaustive sweep; dout_q checked one edge behind the current address.
      prev = 81;
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         addr = 8'(a);
         #1 check("sweep_dout", dout, ref_prod(a));
         check("sweep_dout_q_prev", dout_q, prev);
         @(posedge clk);
         #1 check("sweep_dout_q", dout_q, ref_prod(a));
         prev = ref_prod(a);
      end

      // Random addresses, including symmetry of the table.
      for (int n = 0; n < 200; n++) begin
         v = int'($urandom_range(255));
         step(v, "rand");
         @(negedge clk);
         addr = 8'({v[3:0], v[7:4]});
         #1 check("rand_sym", dout, ref_prod(v));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
